// File: rtl/sysa_ram_feeder.sv
// sysa_ram_feeder: reads `count` consecutive words from a single-port operand
// RAM starting at `base_addr` and streams them on a valid/ready edge port.
//
// Ports:
//   clk, rst            - rising-edge clock, async active-high reset
//   start               - begin a transfer (accepted only while IDLE)
//   base_addr, count    - first address / word count, sampled on start
//   busy, done          - transfer in progress / one-cycle completion pulse
//   ram_en, ram_we      - RAM read enable / write enable (always 0)
//   ram_addr, ram_di    - RAM address / write data (always 0)
//   ram_do              - RAM read data, one cycle after ram_en
//   out_data, out_valid - stream word and valid (head of a 2-entry FIFO)
//   out_ready           - downstream accepts when valid and ready are high
module sysa_ram_feeder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int SKEW   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKEW,
        S_STREAM,
        S_DRAIN
    } state_e;

    localparam logic [ADDR_W:0]   CNT_ONE   = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
    localparam logic [3:0]        SKEW_INIT = (SKEW > 0) ? 4'(SKEW - 1) : 4'd0;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     iss_q;
    logic [ADDR_W:0]     acc_q;
    logic [3:0]          skw_q;
    logic                pend_q;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   mem_q [2];
    logic                wr_q, rd_q;
    logic [1:0]          cnt_q;

    logic                accept;
    logic                pop;
    logic                push;
    logic                issue;
    logic                last_acc;
    logic [2:0]          credit;

    assign accept   = (state_q == S_IDLE) && start;
    assign pop      = (cnt_q != 2'd0) && out_ready;
    assign push     = pend_q;
    assign last_acc = (acc_q == '0) || (pop && acc_q == CNT_ONE);

    // Slots claimed after this cycle's read: buffered + in flight + new - leaving.
    // Keeping this at or below 2 means the FIFO can never overflow.
    assign credit = {1'b0, cnt_q} + {2'b00, pend_q} + 3'd1 - {2'b00, pop};
    assign issue  = (state_q == S_STREAM) && (iss_q != '0) && (credit <= 3'd2);

    assign done_d = (accept && count == '0)
                  || (state_q == S_DRAIN && last_acc);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && count != '0) begin
                    state_d = (SKEW == 0) ? S_STREAM : S_SKEW;
                end
            end
            S_SKEW: begin
                if (skw_q == 4'd0) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (iss_q == '0 || (issue && iss_q == CNT_ONE)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_acc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = done_q;
        ram_en    = issue;
        ram_we    = 1'b0;
        ram_addr  = issue ? ptr_q : '0;
        ram_di    = '0;
        out_valid = (cnt_q != 2'd0);
        out_data  = out_valid ? mem_q[rd_q] : '0;
    end

    // Counters, pointer and read-data FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            iss_q    <= '0;
            acc_q    <= '0;
            skw_q    <= 4'd0;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            done_q <= done_d;
            if (accept) begin
                ptr_q <= base_addr;
                iss_q <= count;
                acc_q <= count;
                skw_q <= SKEW_INIT;
            end else begin
                if (issue) begin
                    ptr_q <= ptr_q + PTR_ONE;
                    iss_q <= iss_q - CNT_ONE;
                end
                if (pop) begin
                    acc_q <= acc_q - CNT_ONE;
                end
                if (state_q == S_SKEW && skw_q != 4'd0) begin
                    skw_q <= skw_q - 4'd1;
                end
            end
            // RAM data arrives the cycle after the read was issued
            pend_q <= issue;
            if (push) begin
                mem_q[wr_q] <= ram_do;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_sysa_ram_feeder.sv
// tb_sysa_ram_feeder: two feeders (SKEW 0 and SKEW 3) on a shared RAM image,
// checked against the expected word/address sequence for each transfer.
module tb_sysa_ram_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        st  [2];
    logic [3:0]  ba  [2];
    logic [4:0]  cn  [2];
    logic        bz  [2];
    logic        dn  [2];
    logic        en  [2];
    logic        we  [2];
    logic [3:0]  ad  [2];
    logic [15:0] di  [2];
    logic [15:0] dq  [2];
    logic [15:0] od  [2];
    logic        ov  [2];
    logic        rdy [2];
    logic [15:0] mem [16];

    int tests;
    int fails;

    always #5 clk = ~clk;

    sysa_ram_feeder #(.DATA_W(16), .ADDR_W(4), .SKEW(0)) u0 (
        .clk(clk), .rst(rst), .start(st[0]), .base_addr(ba[0]),
        .count(cn[0]), .busy(bz[0]), .done(dn[0]), .ram_en(en[0]),
        .ram_we(we[0]), .ram_addr(ad[0]), .ram_di(di[0]), .ram_do(dq[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(rdy[0])
    );

    sysa_ram_feeder #(.DATA_W(16), .ADDR_W(4), .SKEW(3)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .base_addr(ba[1]),
        .count(cn[1]), .busy(bz[1]), .done(dn[1]), .ram_en(en[1]),
        .ram_we(we[1]), .ram_addr(ad[1]), .ram_di(di[1]), .ram_do(dq[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(rdy[1])
    );

    // Registered-read RAM models
    always @(posedge clk) begin
        if (en[0]) dq[0] <= mem[ad[0]];
        if (en[1]) dq[1] <= mem[ad[1]];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input int k, input string tag);
        chk(tag, 32'({bz[k], dn[k], en[k], we[k], ov[k]}), 32'd0);
        chk({tag, "_bus"}, 32'({ad[k], od[k]}), 32'd0);
        chk({tag, "_di"}, 32'(di[k]), 32'd0);
    endtask

    // One transfer on instance k. rmode: 0 ready high, 1 pattern 1,0,0,
    // 2 random. mid: fire a stray start (base 9) in cycle 2. rst_after:
    // if nonzero, reset right after that many words were accepted.
    task automatic xfer(input int k, input int b, input int n,
                        input int rmode, input bit mid, input int rst_after);
        int          skw, iss, acc, last_fire, cyc;
        bit          fin, stall, first_v, done_exp;
        logic [15:0] prev;
        logic [15:0] exp_q [$];
        logic [3:0]  adr_q [$];
        skw = (k == 1) ? 3 : 0;
        for (int i = 0; i < n; i++) begin
            adr_q.push_back(4'((b + i) % 16));
            exp_q.push_back(mem[(b + i) % 16]);
        end
        iss = 0; acc = 0; last_fire = -10;
        fin = 0; stall = 0; first_v = 0; prev = '0;
        @(negedge clk);
        st[k] = 1'b1; ba[k] = 4'(b); cn[k] = 5'(n); rdy[k] = 1'b0;
        for (cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(negedge clk);
            st[k] = mid && (cyc == 2);
            if (mid && cyc == 2) ba[k] = 4'd9;
            case (rmode)
                0:       rdy[k] = 1'b1;
                1:       rdy[k] = (cyc % 3 == 0);
                default: rdy[k] = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (stall) begin
                chk("hold_valid", 32'(ov[k]), 32'd1);
                chk("hold_data", 32'(od[k]), 32'(prev));
            end
            chk("tie_off", 32'({we[k], di[k]}), 32'd0);
            if (en[k]) begin
                if (iss < n) begin
                    chk("addr", 32'(ad[k]), 32'(adr_q[iss]));
                    if (iss == 0) chk("first_en_cyc", cyc, skw);
                end else begin
                    chk("extra_read", 32'd1, 32'd0);
                end
                iss++;
            end
            if (ov[k] && !first_v) begin
                first_v = 1;
                chk("first_valid_cyc", cyc, skw + 2);
            end
            done_exp = (n == 0) ? (cyc == 0)
                                : (acc == n && last_fire == cyc - 1);
            chk("done", 32'(dn[k]), 32'(done_exp));
            chk("busy", 32'(bz[k]), 32'(n != 0 && !done_exp));
            if (ov[k] && rdy[k]) begin
                if (acc < n) chk("data", 32'(od[k]), 32'(exp_q[acc]));
                else         chk("extra_word", 32'd1, 32'd0);
                acc++;
                last_fire = cyc;
            end
            chk("outstanding", 32'(iss - acc <= 2), 32'd1);
            stall = ov[k] && !rdy[k];
            prev  = od[k];
            if (done_exp) fin = 1;
            if (rst_after != 0 && acc == rst_after) break;
        end
        st[k] = 1'b0;
        if (rst_after != 0) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk_zero(k, "reset_mid");
            @(negedge clk);
            rst = 1'b0;
        end else begin
            chk("completed", 32'(fin), 32'd1);
            chk("word_count", acc, n);
            rdy[k] = 1'b0;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; ba[i] = '0; cn[i] = '0; rdy[i] = 1'b0;
        end
        mem[0] = 16'd2; mem[1] = 16'd5; mem[2] = 16'd8;
        mem[3] = 16'd3; mem[4] = 16'd6; mem[5] = 16'd9;
        for (int i = 6; i < 16; i++) mem[i] = 16'($urandom);
        #1 rst = 1'b1;
        #2;
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        @(negedge clk);
        rst = 1'b0;

        xfer(0, 0, 6, 0, 0, 0);
        xfer(0, 0, 6, 1, 0, 0);
        xfer(0, 14, 4, 2, 0, 0);
        xfer(0, 0, 16, 0, 0, 0);
        xfer(1, 0, 6, 0, 0, 0);
        xfer(1, 10, 5, 1, 0, 0);
        xfer(0, 3, 0, 0, 0, 0);
        xfer(1, 7, 0, 0, 0, 0);
        xfer(0, 2, 6, 0, 1, 0);
        xfer(0, 0, 6, 0, 0, 3);
        xfer(0, 0, 2, 0, 0, 0);
        for (int t = 0; t < 8; t++) begin
            xfer(t % 2, int'($urandom_range(0, 15)),
                 int'($urandom_range(1, 16)), 2, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
